qconv_khw_states: RTL and testbench

Kernel-loop sequencer for the quantized convolution engine. One `start` pulse steps through every kernel position (kh, kw) and every input-channel block (ic_high), in that nesting order. For each iteration it first triggers the weight-load and input-tile-read units in parallel, then triggers the MAC array. It sits below the ihw_high loop controller, which waits for its `finish` pulse.

---
 rtl/qconv_khw_states.sv | 187 ++++++++++++++++++
 tb/tb_qconv_khw_states.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qconv_khw_states.sv
//==============================================================================
// Module      : qconv_khw_states
// Description : Kernel-loop sequencer for the quantized convolution engine.
//               A start pulse walks every (kh, kw, ic_high) position, with
//               ic_high innermost and kh outermost. Each iteration triggers
//               the weight loader and the indata reader together, waits for
//               both, triggers the MAC array, waits for it, and then advances
//               the counters. finish pulses in the last JUDGE cycle.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Ports
//   clk            in   clock
//   rst_n          in   synchronous active-low reset
//   start          in   run request, only honoured in IDLE
//   finish         out  one-cycle pulse when the final iteration completes
//   busy           out  high whenever the sequencer is not IDLE
//   kh/kw/ic_high  out  current loop position, stable for a whole iteration
//   start_load     out  one-cycle trigger to weight loader and indata reader
//   finish_weights in   done pulse from weight loader
//   finish_indata  in   done pulse from indata reader
//   start_mac      out  one-cycle trigger to MAC array
//   acc_clear      out  qualifies start_mac on the first iteration
//   acc_last       out  qualifies start_mac on the last iteration
//   finish_mac     in   done pulse from MAC array
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module qconv_khw_states #(
    parameter int KhBitWidth     = 2,
    parameter int KwBitWidth     = 2,
    parameter int IcHighBitWidth = 4,
    parameter int KhNum          = 3,
    parameter int KwNum          = 3,
    parameter int IcHighNum      = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic                      finish,
    output logic                      busy,
    output logic [KhBitWidth-1:0]     kh,
    output logic [KwBitWidth-1:0]     kw,
    output logic [IcHighBitWidth-1:0] ic_high,
    output logic                      start_load,
    input  logic                      finish_weights,
    input  logic                      finish_indata,
    output logic                      start_mac,
    output logic                      acc_clear,
    output logic                      acc_last,
    input  logic                      finish_mac
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TRIG_LOAD = 3'd1,
        ST_WAIT_LOAD = 3'd2,
        ST_TRIG_MAC  = 3'd3,
        ST_WAIT_MAC  = 3'd4,
        ST_JUDGE     = 3'd5
    } state_t;

    localparam logic [KhBitWidth-1:0]     c_kh_last = KhBitWidth'(KhNum - 1);
    localparam logic [KwBitWidth-1:0]     c_kw_last = KwBitWidth'(KwNum - 1);
    localparam logic [IcHighBitWidth-1:0] c_ic_last = IcHighBitWidth'(IcHighNum - 1);

    state_t                      state_q, state_d;
    logic [KhBitWidth-1:0]       kh_q, kh_d;
    logic [KwBitWidth-1:0]       kw_q, kw_d;
    logic [IcHighBitWidth-1:0]   ic_q, ic_d;
    logic                        weights_done_q, weights_done_d;
    logic                        indata_done_q, indata_done_d;
    logic                        mac_done_q, mac_done_d;

    logic                        w_last;
    logic                        w_first;

    assign w_last  = (kh_q == c_kh_last) && (kw_q == c_kw_last) && (ic_q == c_ic_last);
    assign w_first = (kh_q == '0) && (kw_q == '0) && (ic_q == '0);

    //--------------------------------------------------------------------------
    // State and counter registers
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            kh_q           <= '0;
            kw_q           <= '0;
            ic_q           <= '0;
            weights_done_q <= 1'b0;
            indata_done_q  <= 1'b0;
            mac_done_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            kh_q           <= kh_d;
            kw_q           <= kw_d;
            ic_q           <= ic_d;
            weights_done_q <= weights_done_d;
            indata_done_q  <= indata_done_d;
            mac_done_q     <= mac_done_d;
        end
    end

    //--------------------------------------------------------------------------
    // Next state, done latches and loop counters
    //--------------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        kh_d           = kh_q;
        kw_d           = kw_q;
        ic_d           = ic_q;
        weights_done_d = weights_done_q;
        indata_done_d  = indata_done_q;
        mac_done_d     = mac_done_q;

        // Done pulses are captured in any active state. JUDGE clears the
        // latches and takes priority, so a pulse landing there is dropped.
        if (state_q == ST_JUDGE) begin
            weights_done_d = 1'b0;
            indata_done_d  = 1'b0;
            mac_done_d     = 1'b0;
        end else if (state_q != ST_IDLE) begin
            if (finish_weights) weights_done_d = 1'b1;
            if (finish_indata)  indata_done_d  = 1'b1;
            if (finish_mac)     mac_done_d     = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_TRIG_LOAD;
            end
            ST_TRIG_LOAD: begin
                state_d = ST_WAIT_LOAD;
            end
            ST_WAIT_LOAD: begin
                if (weights_done_q && indata_done_q) state_d = ST_TRIG_MAC;
            end
            ST_TRIG_MAC: begin
                state_d = ST_WAIT_MAC;
            end
            ST_WAIT_MAC: begin
                if (mac_done_q) state_d = ST_JUDGE;
            end
            ST_JUDGE: begin
                if (w_last) begin
                    // Counters return to zero so IDLE always presents (0,0,0).
                    state_d = ST_IDLE;
                    kh_d    = '0;
                    kw_d    = '0;
                    ic_d    = '0;
                end else begin
                    state_d = ST_TRIG_LOAD;
                    if (ic_q == c_ic_last) begin
                        ic_d = '0;
                        if (kw_q == c_kw_last) begin
                            kw_d = '0;
                            kh_d = kh_q + KhBitWidth'(1);
                        end else begin
                            kw_d = kw_q + KwBitWidth'(1);
                        end
                    end else begin
                        ic_d = ic_q + IcHighBitWidth'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Output decode: registers only, no path from any input
    //--------------------------------------------------------------------------
    assign busy       = (state_q != ST_IDLE);
    assign start_load = (state_q == ST_TRIG_LOAD);
    assign start_mac  = (state_q == ST_TRIG_MAC);
    assign acc_clear  = (state_q == ST_TRIG_MAC) && w_first;
    assign acc_last   = (state_q == ST_TRIG_MAC) && w_last;
    assign finish     = (state_q == ST_JUDGE) && w_last;
    assign kh         = kh_q;
    assign kw         = kw_q;
    assign ic_high    = ic_q;

endmodule

`default_nettype wire

// File: tb/tb_qconv_khw_states.sv
//==============================================================================
// Module      : tb_qconv_khw_states
// Description : Randomized scoreboard bench for qconv_khw_states. A loop-nest
//               reference model predicts every trigger, its position and its
//               cycle from the chosen unit latencies; a monitor pops and
//               compares whenever the DUT emits a trigger or finish.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_qconv_khw_states;

    localparam int KH = 3;
    localparam int KW = 3;
    localparam int IC = 2;
    localparam int NITER = KH * KW * IC;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Main DUT (default loop sizes)
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       finish, busy, start_load, start_mac, acc_clear, acc_last;
    logic [1:0] kh, kw;
    logic [3:0] ic_high;
    logic       r_fw = 1'b0, r_fi = 1'b0, r_fm = 1'b0, s_fm = 1'b0;
    logic       fm_in;
    assign fm_in = r_fm | s_fm;

    qconv_khw_states dut (
        .clk(clk), .rst_n(rst_n), .start(start), .finish(finish), .busy(busy),
        .kh(kh), .kw(kw), .ic_high(ic_high), .start_load(start_load),
        .finish_weights(r_fw), .finish_indata(r_fi), .start_mac(start_mac),
        .acc_clear(acc_clear), .acc_last(acc_last), .finish_mac(fm_in)
    );

    // Degenerate DUT: single iteration
    logic       start1 = 1'b0;
    logic       finish1, busy1, sl1, sm1, clr1, lst1;
    logic [1:0] kh1, kw1;
    logic [3:0] ic1;
    logic       fw1 = 1'b0, fm1 = 1'b0, sl1_d = 1'b0, sm1_d = 1'b0;

    qconv_khw_states #(
        .KhNum(1), .KwNum(1), .IcHighNum(1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .finish(finish1), .busy(busy1),
        .kh(kh1), .kw(kw1), .ic_high(ic1), .start_load(sl1),
        .finish_weights(fw1), .finish_indata(fw1), .start_mac(sm1),
        .acc_clear(clr1), .acc_last(lst1), .finish_mac(fm1)
    );

    typedef struct {
        int t;
        int kh;
        int kw;
        int ic;
        bit clr;
        bit lst;
    } ev_t;

    ev_t q_load[$];
    ev_t q_mac[$];
    int  q_fin[$];
    int  q1_fin[$];

    int n_vec = 0, n_err = 0, done_cnt = 0;
    int busy_from = 1, busy_to = 0;
    bit mon_en = 1'b0;
    int lw = 1, li = 1, lm = 1;
    int wcnt = 0, icnt = 0, mcnt = 0;
    ev_t e_l, e_m;
    int  f_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Loader / MAC responders with programmable latency
    always @(negedge clk) begin
        r_fw = 1'b0;
        r_fi = 1'b0;
        r_fm = 1'b0;
        if (wcnt > 0) begin wcnt--; if (wcnt == 0) r_fw = 1'b1; end
        if (icnt > 0) begin icnt--; if (icnt == 0) r_fi = 1'b1; end
        if (mcnt > 0) begin mcnt--; if (mcnt == 0) r_fm = 1'b1; end
        if (start_load) begin wcnt = lw; icnt = li; end
        if (start_mac)  mcnt = lm;
    end

    always @(negedge clk) begin
        fw1   = sl1_d;
        fm1   = sm1_d;
        sl1_d = sl1;
        sm1_d = sm1;
    end

    // Monitor for the main DUT
    always @(negedge clk) begin
        if (mon_en) begin
            check("busy", 32'(busy), 32'(cyc >= busy_from && cyc <= busy_to));
            if (start_load) begin
                if (q_load.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_start_load: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    e_l = q_load.pop_front();
                    check("load_cycle", cyc, e_l.t);
                    check("load_kh", 32'(kh), e_l.kh);
                    check("load_kw", 32'(kw), e_l.kw);
                    check("load_ic", 32'(ic_high), e_l.ic);
                end
            end
            if (start_mac) begin
                if (q_mac.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_start_mac: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    e_m = q_mac.pop_front();
                    check("mac_cycle", cyc, e_m.t);
                    check("mac_pos", {kh, kw, ic_high}, {e_m.kh[1:0], e_m.kw[1:0], e_m.ic[3:0]});
                    check("acc_flags", {acc_clear, acc_last}, {e_m.clr, e_m.lst});
                end
            end else begin
                check("acc_flags_outside_mac", {acc_clear, acc_last}, 0);
            end
            if (finish) begin
                done_cnt++;
                if (q_fin.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_finish: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    f_exp = q_fin.pop_front();
                    check("finish_cycle", cyc, f_exp);
                end
            end
        end
    end

    // Monitor for the degenerate DUT
    always @(negedge clk) begin
        if (mon_en) begin
            if (sm1) check("deg_acc_flags", {clr1, lst1}, 2'b11);
            if (finish1) begin
                if (q1_fin.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL deg_unexpected_finish: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    check("deg_finish_cycle", cyc, q1_fin.pop_front());
                end
            end
        end
    end

    // Reference model: enumerate the loop nest and time every event.
    task automatic predict(input int s, input int a_lw, input int a_li, input int a_lm);
        int m, t, i;
        ev_t ev;
        m = (a_lw > a_li) ? a_lw : a_li;
        t = m + a_lm + 5;
        i = 0;
        for (int a = 0; a < KH; a++)
            for (int b = 0; b < KW; b++)
                for (int c = 0; c < IC; c++) begin
                    ev.kh  = a;
                    ev.kw  = b;
                    ev.ic  = c;
                    ev.clr = (i == 0);
                    ev.lst = (i == NITER - 1);
                    ev.t   = s + 1 + i * t;
                    q_load.push_back(ev);
                    ev.t   = s + 3 + m + i * t;
                    q_mac.push_back(ev);
                    i++;
                end
        q_fin.push_back(s + NITER * t);
        busy_from = s + 1;
        busy_to   = s + NITER * t;
    endtask

    // Called at a negedge with the DUT in IDLE; returns at the negedge after finish.
    task automatic do_run(input int a_lw, input int a_li, input int a_lm, input bit spur);
        int s, prev, waited, budget, m;
        lw = a_lw; li = a_li; lm = a_lm;
        m = (a_lw > a_li) ? a_lw : a_li;
        budget = NITER * (m + a_lm + 5);
        start = 1'b1;
        s = cyc;
        predict(s, a_lw, a_li, a_lm);
        @(negedge clk);
        start = 1'b0;
        prev = done_cnt;
        waited = 0;
        while (done_cnt == prev && waited < budget + 50) begin
            @(posedge clk);
            waited++;
            if (spur) start = (waited % 9 == 4) && (waited < budget - 5);
        end
        start = 1'b0;
        if (done_cnt == prev) begin
            n_vec++; n_err++;
            $display("FAIL run_timeout: got no finish expected finish within %0d cycles", budget + 50);
            q_load.delete(); q_mac.delete(); q_fin.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int s, m, c, prev;

        repeat (3) @(negedge clk);
        check("rst_outputs", {finish, busy, start_load, start_mac, acc_clear, acc_last, kh, kw, ic_high}, 0);
        check("rst_outputs_deg", {finish1, busy1, sl1, sm1, clr1, lst1, kh1, kw1, ic1}, 0);
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Stray MAC done pulses while idle must not pre-set the latch.
        @(negedge clk) s_fm = 1'b1;
        @(negedge clk) s_fm = 1'b0;

        do_run(3, 5, 4, 1'b1);          // default scenario, stray starts mid-run
        do_run(12, 2, 3, 1'b0);         // indata 10 cycles before weights
        do_run(4, 4, 2, 1'b0);          // both loaders finish together
        for (int r = 0; r < 4; r++)     // back-to-back random latencies
            do_run(int'($urandom_range(1, 8)), int'($urandom_range(1, 8)),
                   int'($urandom_range(1, 8)), r[0]);

        // Reset during WAIT_MAC of iteration 7
        repeat (4) @(negedge clk);
        lw = 3; li = 5; lm = 4;
        m = 5;
        start = 1'b1;
        s = cyc;
        predict(s, 3, 5, 4);
        @(negedge clk) start = 1'b0;
        c = s + m + 4 + 6 * (m + 4 + 5);
        prev = done_cnt;
        while (cyc < c) @(negedge clk);
        rst_n = 1'b0;
        q_load.delete(); q_mac.delete(); q_fin.delete();
        busy_to = cyc;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrun_rst_outputs", {finish, busy, start_load, start_mac, acc_clear, acc_last, kh, kw, ic_high}, 0);
        repeat (3) @(negedge clk);
        s_fm = 1'b1;
        @(negedge clk) s_fm = 1'b0;
        repeat (16) @(negedge clk);
        check("no_finish_after_abort", done_cnt, prev);

        do_run(int'($urandom_range(1, 6)), int'($urandom_range(1, 6)),
               int'($urandom_range(1, 6)), 1'b0);   // replays from (0,0,0)

        // Degenerate single-iteration block, restarted the cycle after finish
        start1 = 1'b1;
        s = cyc;
        q1_fin.push_back(s + 7);
        @(negedge clk) start1 = 1'b0;
        repeat (7) @(negedge clk);
        start1 = 1'b1;
        q1_fin.push_back(s + 15);
        @(negedge clk) start1 = 1'b0;
        repeat (12) @(negedge clk);

        check("leftover_events", q_load.size() + q_mac.size() + q_fin.size() + q1_fin.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
